// File: rtl/encoder_hidden_pool.sv
// Temporal majority-vote pooling of binarized encoder hidden vectors.
// Counts ones per bit over a sequence, then streams the pooled vector out as words.
module encoder_hidden_pool #(
  parameter int unsigned NUM_STEPS = 30,
  parameter int unsigned VEC_W     = 256,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [VEC_W-1:0] in_data,
  input  logic             in_valid,
  input  logic             frame_clr,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             frame_done,
  output logic [CNT_W-1:0] step_cnt,
  output logic             drop_err
);

  localparam int unsigned NUM_WORDS = VEC_W / OUT_W;
  localparam int unsigned K_W       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic {ACC, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q [VEC_W];
  logic [CNT_W-1:0]   cnt_d [VEC_W];
  logic [CNT_W-1:0]   cnt_upd [VEC_W];
  logic [CNT_W-1:0]   step_q, step_d;
  logic [K_W-1:0]     k_q, k_d, k_nxt;
  logic [VEC_W-1:0]   pooled_q, pooled_d, pooled_upd;
  logic [OUT_W-1:0]   words_q [NUM_WORDS];
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic               frame_done_q, frame_done_d;
  logic               drop_err_q, drop_err_d;
  logic               xfer;
  logic               clr_all;

  // Post-update counts and their majority decision, used on the final step
  always_comb begin
    for (int b = 0; b < VEC_W; b++) begin
      cnt_upd[b]    = cnt_q[b] + CNT_W'(in_data[b]);
      pooled_upd[b] = {cnt_upd[b], 1'b0} > (CNT_W+1)'(NUM_STEPS);
    end
  end

  always_comb begin
    for (int w = 0; w < NUM_WORDS; w++) begin
      words_q[w] = pooled_q[w*OUT_W +: OUT_W];
    end
  end

  assign xfer  = out_valid_q && out_ready;
  assign k_nxt = k_q + K_W'(1);

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    step_d       = step_q;
    k_d          = k_q;
    pooled_d     = pooled_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    frame_done_d = 1'b0;
    drop_err_d   = drop_err_q;
    clr_all      = 1'b0;

    if (frame_clr) begin
      state_d = ACC;
      clr_all = 1'b1;
    end else begin
      unique case (state_q)
        ACC: begin
          if (in_valid) begin
            cnt_d  = cnt_upd;
            step_d = step_q + CNT_W'(1);
            if (step_q == CNT_W'(NUM_STEPS - 1)) begin
              state_d     = DRAIN;
              pooled_d    = pooled_upd;
              k_d         = '0;
              out_valid_d = 1'b1;
              out_data_d  = pooled_upd[OUT_W-1:0];
              out_last_d  = (NUM_WORDS == 1);
            end
          end
        end
        DRAIN: begin
          if (in_valid) drop_err_d = 1'b1;
          if (xfer) begin
            if (k_q == K_W'(NUM_WORDS - 1)) begin
              state_d      = ACC;
              clr_all      = 1'b1;
              frame_done_d = 1'b1;
            end else begin
              k_d        = k_nxt;
              out_data_d = words_q[k_nxt];
              out_last_d = (k_nxt == K_W'(NUM_WORDS - 1));
            end
          end
        end
        default: state_d = ACC;
      endcase
    end

    if (clr_all) begin
      for (int b = 0; b < VEC_W; b++) cnt_d[b] = '0;
      step_d      = '0;
      k_d         = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      out_data_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ACC;
      for (int b = 0; b < VEC_W; b++) cnt_q[b] <= '0;
      step_q       <= '0;
      k_q          <= '0;
      pooled_q     <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      drop_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      step_q       <= step_d;
      k_q          <= k_d;
      pooled_q     <= pooled_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
      drop_err_q   <= drop_err_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign frame_done = frame_done_q;
  assign step_cnt   = step_q;
  assign drop_err   = drop_err_q;

endmodule

// File: tb/tb_encoder_hidden_pool.sv
// Directed bench for encoder_hidden_pool with a word scoreboard fed by a bit-count model.
module tb_encoder_hidden_pool;

  localparam int unsigned NUM_STEPS = 30;
  localparam int unsigned VEC_W     = 256;
  localparam int unsigned OUT_W     = 16;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned NUM_WORDS = VEC_W / OUT_W;

  logic             clk = 1'b0;
  logic             rst;
  logic [VEC_W-1:0] in_data;
  logic             in_valid;
  logic             frame_clr;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             frame_done;
  logic [CNT_W-1:0] step_cnt;
  logic             drop_err;

  encoder_hidden_pool #(
    .NUM_STEPS(NUM_STEPS), .VEC_W(VEC_W), .OUT_W(OUT_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .frame_clr(frame_clr), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .frame_done(frame_done),
    .step_cnt(step_cnt), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             last;
  } exp_t;

  exp_t             sb[$];
  int               checks = 0;
  int               errors = 0;
  int               xfers  = 0;
  int               mcnt [VEC_W];
  int               msteps = 0;
  logic             prev_stall = 1'b0;
  logic [OUT_W-1:0] prev_data  = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int b = 0; b < VEC_W; b++) mcnt[b] = 0;
    msteps = 0;
  endtask

  // Reference pooling: strict majority over NUM_STEPS, words pushed LSW first
  task automatic model_vec(input logic [VEC_W-1:0] v);
    logic [VEC_W-1:0] p;
    exp_t e;
    for (int b = 0; b < VEC_W; b++) mcnt[b] += int'(v[b]);
    msteps++;
    if (msteps == NUM_STEPS) begin
      for (int b = 0; b < VEC_W; b++) p[b] = (2 * mcnt[b] > NUM_STEPS);
      for (int w = 0; w < NUM_WORDS; w++) begin
        e.data = p[w*OUT_W +: OUT_W];
        e.last = (w == NUM_WORDS - 1);
        sb.push_back(e);
      end
      model_clear();
    end
  endtask

  function automatic logic [VEC_W-1:0] rand_vec();
    logic [VEC_W-1:0] v;
    for (int i = 0; i < VEC_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_vec(input logic [VEC_W-1:0] v);
    step();
    in_valid = 1'b1;
    in_data  = v;
    model_vec(v);
  endtask

  task automatic idle();
    step();
    in_valid = 1'b0;
  endtask

  // Run until frame_done; mode 1 toggles out_ready as 1,0,0,1,...
  task automatic wait_done(input int mode, output int n);
    n = 0;
    do begin
      step();
      n++;
      if (frame_done) break;
      out_ready = (mode == 0) ? 1'b1 : ((n % 4 == 0) || (n % 4 == 3));
    end while (n < 200);
    chk("frame_done_seen", 32'(frame_done), 1);
  endtask

  // Output monitor: pops the scoreboard on every transfer, checks stall stability
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid) chk("hold_data", 32'(out_data), 32'(prev_data));
      if (out_valid && out_ready) begin
        chk("sb_has_word", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("word_data", 32'(out_data), 32'(e.data));
          chk("word_last", 32'(out_last), 32'(e.last));
        end
        xfers++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    int n;
    int x0;
    logic [VEC_W-1:0] v;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; frame_clr = 1'b0;
    model_clear();
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_drop_err", 32'(drop_err), 0);
    chk("rst_step_cnt", 32'(step_cnt), 0);
    step(); step();
    rst = 1'b0;

    // All-ones frame at full throughput
    out_ready = 1'b1;
    x0 = xfers;
    for (int t = 0; t < NUM_STEPS; t++) drive_vec('1);
    idle();
    chk("ones_first_valid", 32'(out_valid), 1);
    chk("ones_first_data", 32'(out_data), 32'hFFFF);
    chk("ones_step_cnt_full", 32'(step_cnt), NUM_STEPS);
    wait_done(0, n);
    chk("ones_drain_cycles", 32'(n), NUM_WORDS);
    chk("ones_xfers", 32'(xfers - x0), NUM_WORDS);
    chk("ones_step_cnt_clr", 32'(step_cnt), 0);
    chk("ones_valid_low", 32'(out_valid), 0);
    step();
    chk("ones_done_pulse", 32'(frame_done), 0);

    // Majority threshold: 15 of 30 is a tie (0), 16 of 30 wins (1)
    for (int t = 0; t < NUM_STEPS; t++) begin
      v = '0;
      v[0] = (t < 15);
      v[1] = (t < 16);
      v[VEC_W-1] = 1'b1;
      drive_vec(v);
    end
    idle();
    chk("thr_word0", 32'(out_data), 32'h0002);
    wait_done(0, n);

    // Backpressure
    x0 = xfers;
    out_ready = 1'b1;
    for (int t = 0; t < NUM_STEPS; t++) drive_vec('1);
    idle();
    wait_done(1, n);
    chk("bp_xfers", 32'(xfers - x0), NUM_WORDS);
    out_ready = 1'b1;

    // frame_clr after 5 transfers, with a simultaneous in_valid
    out_ready = 1'b0;
    for (int t = 0; t < NUM_STEPS; t++) drive_vec('1);
    idle();
    x0 = xfers;
    out_ready = 1'b1;
    repeat (5) step();
    out_ready = 1'b0; frame_clr = 1'b1; in_valid = 1'b1; in_data = rand_vec();
    step();
    frame_clr = 1'b0; in_valid = 1'b0;
    chk("clr_xfers", 32'(xfers - x0), 5);
    chk("clr_valid", 32'(out_valid), 0);
    chk("clr_last", 32'(out_last), 0);
    chk("clr_no_done", 32'(frame_done), 0);
    chk("clr_step_cnt", 32'(step_cnt), 0);
    chk("clr_no_drop", 32'(drop_err), 0);
    sb.delete();
    model_clear();
    step();
    chk("clr_no_done2", 32'(frame_done), 0);
    out_ready = 1'b1;
    for (int t = 0; t < NUM_STEPS; t++) drive_vec({(VEC_W/16){16'hAAAA}});
    idle();
    chk("aa_word0", 32'(out_data), 32'hAAAA);
    wait_done(0, n);

    // Vector arriving during drain is dropped and flagged
    out_ready = 1'b0;
    for (int t = 0; t < NUM_STEPS; t++) drive_vec(rand_vec());
    idle();
    chk("drop_before", 32'(drop_err), 0);
    in_valid = 1'b1; in_data = '1;
    step();
    in_valid = 1'b0;
    chk("drop_set", 32'(drop_err), 1);
    out_ready = 1'b1;
    wait_done(0, n);
    chk("drop_sticky", 32'(drop_err), 1);
    for (int t = 0; t < NUM_STEPS; t++) drive_vec(rand_vec());
    idle();
    wait_done(0, n);
    chk("drop_sticky2", 32'(drop_err), 1);

    // Async reset in the middle of accumulation
    for (int t = 0; t < 12; t++) drive_vec(rand_vec());
    idle();
    chk("mid_step_cnt", 32'(step_cnt), 12);
    rst = 1'b1;
    #1;
    chk("mid_rst_step_cnt", 32'(step_cnt), 0);
    chk("mid_rst_drop", 32'(drop_err), 0);
    chk("mid_rst_valid", 32'(out_valid), 0);
    model_clear();
    step(); step();
    rst = 1'b0;
    for (int t = 0; t < NUM_STEPS; t++) drive_vec('0);
    idle();
    chk("zero_first_valid", 32'(out_valid), 1);
    wait_done(0, n);
    step();
    chk("sb_drained", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/encoder_hidden_pool.md
Name: encoder_hidden_pool

Overview:
- Downstream consumer of the binarized encoder hidden-state stage.
- Accepts one 256-bit binary hidden vector per time step over a 30-step sequence and keeps a per-bit count of ones.
- At sequence end, forms a majority-vote (temporal pooled) 256-bit vector and streams it out as sixteen 16-bit words over a valid/ready handshake, matching the 16-bit input width of the next binary layer.

Parameters:
- NUM_STEPS, 30, time steps per sequence.
- VEC_W, 256, hidden vector width.
- OUT_W, 16, output word width; VEC_W must be a multiple of OUT_W.
- CNT_W, 5, per-bit counter width; must hold NUM_STEPS.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  VEC_W  binary hidden vector for one time step.
- in_valid  input  1  single-cycle qualifier for in_data; no backpressure is possible.
- frame_clr  input  1  synchronous abort/clear of the current sequence.
- out_data  output  OUT_W  pooled word.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- out_last  output  1  high with the final word (index VEC_W/OUT_W-1).
- frame_done  output  1  one-cycle pulse after the last word transfers.
- step_cnt  output  CNT_W  number of vectors accepted in the current sequence.
- drop_err  output  1  sticky; a vector arrived while not accepting.

Behaviour:
- Reset (rst=1, async): state=ACC, all counters and step_cnt cleared, snapshot register cleared, word index cleared.
- Reset values of outputs: out_data=0, out_valid=0, out_last=0, frame_done=0, drop_err=0.
- States: ACC, DRAIN.
- ACC, per in_valid:
  - cnt[b] += in_data[b] for every b in 0..VEC_W-1.
  - step_cnt += 1.
  - Counters never exceed NUM_STEPS, so no saturation logic.
- ACC to DRAIN: on the cycle the NUM_STEPS-th in_valid is accepted.
  - Next cycle: state=DRAIN, word index=0, out_valid=1.
  - Snapshot pooled[b] = (2*cnt_final[b] > NUM_STEPS), where cnt_final includes the last vector. Compute the comparison from the post-update count.
  - Tie (cnt==15 at NUM_STEPS=30) gives 0; cnt>=16 gives 1.
  - Latency: last in_valid at edge N, first word valid after edge N+1.
- DRAIN:
  - out_data = pooled[OUT_W*k +: OUT_W], where k is the word index, LSW first.
  - Transfer occurs when out_valid && out_ready. On transfer, k increments and the next word is presented the following cycle.
  - out_data and out_last hold stable while out_valid && !out_ready.
  - out_last = (k == VEC_W/OUT_W-1).
  - Full-throughput drain (out_ready held high) takes exactly 16 cycles.
- DRAIN to ACC: on transfer of the last word.
  - Next cycle: out_valid=0, frame_done=1 for one cycle.
  - Counters, step_cnt and k cleared; a new sequence is accepted from that cycle on.
- in_valid while in DRAIN: vector discarded, counters unchanged, drop_err set. drop_err clears only on rst.
- frame_clr=1: highest priority after rst.
  - Next cycle: state=ACC, counters/step_cnt/k cleared, out_valid=0, out_last=0, no frame_done pulse.
  - An in_valid in the same cycle as frame_clr is discarded without setting drop_err.
- out_ready while out_valid=0: ignored.
- Snapshot register is VEC_W bits. Counters may be a flat register array; no RAM required.

Test Plan:
- All-ones: 30 valid cycles of in_data=all 1s, out_ready=1 → 16 words of 0xFFFF on consecutive cycles; first word one cycle after the 30th in_valid; out_last on word 15; frame_done pulse next cycle; step_cnt back to 0.
- Threshold: bit 0 set in 15 vectors, bit 1 in 16, bit 255 in 30, others 0 → word0=0x0002, word15=0x8000, words 1..14=0x0000.
- Backpressure: all-ones frame, out_ready toggled 1,0,0,1,… → each word held stable while out_ready=0; exactly 16 transfers; out_last only on the 16th.
- Drop: in_valid pulsed during DRAIN → drop_err=1 and stays 1; pooled output unchanged; next frame pools correctly.
- frame_clr mid-DRAIN after 5 transfers → out_valid=0 next cycle, no frame_done; new 30-vector frame of 0xAAAA… pattern drains as 16 × 0xAAAA.
- rst asserted after 12 vectors mid-ACC → outputs zero immediately; after release a full 30-vector all-zero frame yields 16 × 0x0000.
